// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared definitions for the hazard control unit: FSM encoding, forward selects,
// default register-address width and the stall down-counter width helper.
package hazard_ctrl_unit_pkg;

  localparam int NB_REG_ADDR_DEF = 5;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_STALL = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // A zero-width counter is illegal, so LOAD_EXTRA=0 still gets one bit.
  function automatic int cnt_width(input int extra);
    return (extra > 0) ? $clog2(extra + 1) : 1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_match.sv
// Source/producer register match: equal address, source actually read,
// producer enabled, and register 0 never matches.
module hazard_match
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int NB_REG_ADDR = NB_REG_ADDR_DEF
) (
  input  logic [NB_REG_ADDR-1:0] i_src,
  input  logic                   i_use,
  input  logic [NB_REG_ADDR-1:0] i_dst,
  input  logic                   i_en,
  output logic                   o_match
);

  assign o_match = i_use & i_en & (i_src == i_dst) & (|i_dst);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard control: load-use / branch / RAW stall FSM, forward selects, stall-cycle counter.
// Macro HAZARD_FORWARDING_EN: defined -> forwarding; undefined -> every RAW stalls until wb.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int NB_REG_ADDR = NB_REG_ADDR_DEF,
  parameter int LOAD_EXTRA  = 0,
  parameter int NB_PERF     = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic [NB_REG_ADDR-1:0] i_rs,
  input  logic [NB_REG_ADDR-1:0] i_rt,
  input  logic                   i_use_rs,
  input  logic                   i_use_rt,
  input  logic                   i_jmp_branch,
  input  logic                   i_we_exec,
  input  logic                   i_re_exec,
  input  logic [NB_REG_ADDR-1:0] i_rd_exec,
  input  logic                   i_we_mem,
  input  logic                   i_re_mem,
  input  logic [NB_REG_ADDR-1:0] i_rd_mem,
  output logic                   o_stall,
  output logic [1:0]             o_fwd_rs,
  output logic [1:0]             o_fwd_rt,
  output logic [NB_PERF-1:0]     o_stall_cnt
);

  // state   | meaning
  // S_IDLE  | stall follows combinational hazard detection
  // S_STALL | extra load-latency cycles, r_cnt counts valid cycles down to 1
  localparam int NB_CNT = cnt_width(LOAD_EXTRA);

  state_t              r_state;
  logic [NB_CNT-1:0]   r_cnt;
  logic [NB_PERF-1:0]  r_stall_cnt;

  logic w_en_exec;
  logic w_en_mem;
  logic w_rs_exec;
  logic w_rt_exec;
  logic w_rs_mem;
  logic w_rt_mem;
  logic w_hz_ld;
  logic w_hz_br;
  logic w_hz_raw;
  logic w_hz;

  assign w_en_exec = i_we_exec | i_re_exec;
  assign w_en_mem  = i_we_mem  | i_re_mem;

  hazard_match #(.NB_REG_ADDR(NB_REG_ADDR)) u_match_rs_exec (
    .i_src(i_rs), .i_use(i_use_rs), .i_dst(i_rd_exec), .i_en(w_en_exec), .o_match(w_rs_exec)
  );
  hazard_match #(.NB_REG_ADDR(NB_REG_ADDR)) u_match_rt_exec (
    .i_src(i_rt), .i_use(i_use_rt), .i_dst(i_rd_exec), .i_en(w_en_exec), .o_match(w_rt_exec)
  );
  hazard_match #(.NB_REG_ADDR(NB_REG_ADDR)) u_match_rs_mem (
    .i_src(i_rs), .i_use(i_use_rs), .i_dst(i_rd_mem), .i_en(w_en_mem), .o_match(w_rs_mem)
  );
  hazard_match #(.NB_REG_ADDR(NB_REG_ADDR)) u_match_rt_mem (
    .i_src(i_rt), .i_use(i_use_rt), .i_dst(i_rd_mem), .i_en(w_en_mem), .o_match(w_rt_mem)
  );

  assign w_hz_ld = i_re_exec & (w_rs_exec | w_rt_exec);
  // Branches resolve in decode, so even an ALU result still in exec is too late.
  assign w_hz_br = i_jmp_branch & ((i_we_exec & (w_rs_exec | w_rt_exec)) |
                                   (i_re_mem  & (w_rs_mem  | w_rt_mem)));

`ifdef HAZARD_FORWARDING_EN
  logic [1:0] w_fwd_rs;
  logic [1:0] w_fwd_rt;

  assign w_hz_raw = 1'b0;

  always_comb begin
    w_fwd_rs = FWD_RF;
    if (w_rs_exec & i_we_exec & ~i_re_exec) w_fwd_rs = FWD_MEM;
    else if (w_rs_mem & i_we_mem)           w_fwd_rs = FWD_WB;
    w_fwd_rt = FWD_RF;
    if (w_rt_exec & i_we_exec & ~i_re_exec) w_fwd_rt = FWD_MEM;
    else if (w_rt_mem & i_we_mem)           w_fwd_rt = FWD_WB;
  end

  assign o_fwd_rs = (i_valid & ~o_stall) ? w_fwd_rs : FWD_RF;
  assign o_fwd_rt = (i_valid & ~o_stall) ? w_fwd_rt : FWD_RF;
`else
  assign w_hz_raw = (i_we_exec & (w_rs_exec | w_rt_exec)) |
                    (i_we_mem  & (w_rs_mem  | w_rt_mem));
  assign o_fwd_rs = FWD_RF;
  assign o_fwd_rt = FWD_RF;
`endif

  assign w_hz        = w_hz_ld | w_hz_br | w_hz_raw;
  assign o_stall     = i_valid & ((r_state == S_STALL) | w_hz);
  assign o_stall_cnt = r_stall_cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
    end else if (i_valid) begin
      if (o_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + NB_PERF'(1);
      case (r_state)
        S_IDLE: begin
          if (w_hz_ld && (LOAD_EXTRA > 0)) begin
            r_state <= S_STALL;
            r_cnt   <= NB_CNT'(LOAD_EXTRA);
          end
        end
        S_STALL: begin
          if (r_cnt == NB_CNT'(1)) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - NB_CNT'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: two instances (LOAD_EXTRA 0 with a 2-bit
// counter, LOAD_EXTRA 2 with a 16-bit counter) share directed stimulus.
module tb_hazard_ctrl_unit;

  localparam int NB = 5;
`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          i_clock;
  logic          i_reset;
  logic          i_valid;
  logic [NB-1:0] i_rs, i_rt, i_rd_exec, i_rd_mem;
  logic          i_use_rs, i_use_rt, i_jmp_branch;
  logic          i_we_exec, i_re_exec, i_we_mem, i_re_mem;

  logic          o_stall_0, o_stall_2;
  logic [1:0]    o_fwd_rs_0, o_fwd_rt_0, o_fwd_rs_2, o_fwd_rt_2;
  logic [1:0]    o_stall_cnt_0;
  logic [15:0]   o_stall_cnt_2;

  hazard_ctrl_unit #(.NB_REG_ADDR(NB), .LOAD_EXTRA(0), .NB_PERF(2)) u_dut0 (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid),
    .i_rs(i_rs), .i_rt(i_rt), .i_use_rs(i_use_rs), .i_use_rt(i_use_rt),
    .i_jmp_branch(i_jmp_branch),
    .i_we_exec(i_we_exec), .i_re_exec(i_re_exec), .i_rd_exec(i_rd_exec),
    .i_we_mem(i_we_mem), .i_re_mem(i_re_mem), .i_rd_mem(i_rd_mem),
    .o_stall(o_stall_0), .o_fwd_rs(o_fwd_rs_0), .o_fwd_rt(o_fwd_rt_0),
    .o_stall_cnt(o_stall_cnt_0)
  );

  hazard_ctrl_unit #(.NB_REG_ADDR(NB), .LOAD_EXTRA(2), .NB_PERF(16)) u_dut2 (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid),
    .i_rs(i_rs), .i_rt(i_rt), .i_use_rs(i_use_rs), .i_use_rt(i_use_rt),
    .i_jmp_branch(i_jmp_branch),
    .i_we_exec(i_we_exec), .i_re_exec(i_re_exec), .i_rd_exec(i_rd_exec),
    .i_we_mem(i_we_mem), .i_re_mem(i_re_mem), .i_rd_mem(i_rd_mem),
    .o_stall(o_stall_2), .o_fwd_rs(o_fwd_rs_2), .o_fwd_rt(o_fwd_rt_2),
    .o_stall_cnt(o_stall_cnt_2)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  typedef struct {
    bit         sel2;
    logic       stall;
    logic [1:0] frs;
    logic [1:0] frt;
    int         cnt;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  exp_t       e;
  logic       a_st;
  logic [1:0] a_frs, a_frt;
  int         a_cnt;

  // Monitor: compares the selected instance at every negedge that has an expectation.
  always @(negedge i_clock) begin
    if (exp_q.size() > 0) begin
      e     = exp_q.pop_front();
      a_st  = e.sel2 ? o_stall_2  : o_stall_0;
      a_frs = e.sel2 ? o_fwd_rs_2 : o_fwd_rs_0;
      a_frt = e.sel2 ? o_fwd_rt_2 : o_fwd_rt_0;
      a_cnt = e.sel2 ? int'(o_stall_cnt_2) : int'(o_stall_cnt_0);
      checks++;
      if (a_st !== e.stall) begin
        errors++;
        $display("FAIL %s stall got %0b want %0b", e.name, a_st, e.stall);
      end
      checks++;
      if (a_frs !== e.frs) begin
        errors++;
        $display("FAIL %s fwd_rs got %b want %b", e.name, a_frs, e.frs);
      end
      checks++;
      if (a_frt !== e.frt) begin
        errors++;
        $display("FAIL %s fwd_rt got %b want %b", e.name, a_frt, e.frt);
      end
      if (e.cnt >= 0) begin
        checks++;
        if (a_cnt != e.cnt) begin
          errors++;
          $display("FAIL %s stall_cnt got %0d want %0d", e.name, a_cnt, e.cnt);
        end
      end
    end
  end

  task automatic step(input bit rst, input bit v, input int rs, input bit urs,
                      input int rt, input bit urt, input bit br,
                      input bit we_e, input bit re_e, input int rd_e,
                      input bit we_m, input bit re_m, input int rd_m,
                      input bit sel2, input bit x_st, input int x_frs, input int x_frt,
                      input int x_cnt, input string nm);
    exp_t x;
    @(posedge i_clock);
    #1;
    i_reset      = rst;
    i_valid      = v;
    i_rs         = NB'(rs);
    i_use_rs     = urs;
    i_rt         = NB'(rt);
    i_use_rt     = urt;
    i_jmp_branch = br;
    i_we_exec    = we_e;
    i_re_exec    = re_e;
    i_rd_exec    = NB'(rd_e);
    i_we_mem     = we_m;
    i_re_mem     = re_m;
    i_rd_mem     = NB'(rd_m);
    x.sel2  = sel2;
    x.stall = x_st;
    x.frs   = 2'(x_frs);
    x.frt   = 2'(x_frt);
    x.cnt   = x_cnt;
    x.name  = nm;
    exp_q.push_back(x);
  endtask

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_rs = '0; i_rt = '0; i_use_rs = 1'b0; i_use_rt = 1'b0;
    i_jmp_branch = 1'b0; i_we_exec = 1'b0; i_re_exec = 1'b0; i_rd_exec = '0;
    i_we_mem = 1'b0; i_re_mem = 1'b0; i_rd_mem = '0;

    // reset state
    step(1,0, 0,0,0,0,0, 0,0,0, 0,0,0, 0, 0,0,0, -1, "rst_hold");
    step(1,1, 0,0,0,0,0, 0,0,0, 0,0,0, 0, 0,0,0,  0, "rst_cnt0");
    step(0,1, 0,0,0,0,0, 0,0,0, 0,0,0, 1, 0,0,0,  0, "rst_cnt2");

    // load-use, LOAD_EXTRA=0
    step(0,1, 3,1,0,0,0, 1,1,3, 0,0,0, 0, 1,0,0, 0, "ld_use");
    step(0,1, 3,1,0,0,0, 0,0,0, 1,1,3, 0, FWD ? 0 : 1, FWD ? 2 : 0, 0, 1, "ld_fwd_wb");
    step(0,1, 0,0,0,0,0, 0,0,0, 0,0,0, 0, 0,0,0, FWD ? 1 : 2, "ld_done");

    // load-use with two extra cycles, i_valid dropped mid-stall
    step(1,1, 0,0,0,0,0, 0,0,0, 0,0,0, 1, 0,0,0, -1, "rst_s2");
    step(0,1, 3,1,0,0,0, 1,1,3, 0,0,0, 1, 1,0,0, 0, "x_ld_use");
    step(0,1, 3,1,0,0,0, 0,0,0, 1,1,3, 1, 1,0,0, 1, "x_stall1");
    step(0,0, 3,1,0,0,0, 0,0,0, 1,1,3, 1, 0,0,0, 2, "x_gap1");
    step(0,0, 3,1,0,0,0, 0,0,0, 1,1,3, 1, 0,0,0, 2, "x_gap2");
    step(0,1, 3,1,0,0,0, 0,0,0, 0,0,0, 1, 1,0,0, 2, "x_stall2");
    step(0,1, 3,1,0,0,0, 0,0,0, 0,0,0, 1, 0,0,0, 3, "x_done");

    // reset in the middle of an extra-latency stall
    step(0,1, 3,1,0,0,0, 1,1,3, 0,0,0, 1, 1,0,0, 3, "r_ld_use");
    step(1,1, 3,1,0,0,0, 0,0,0, 0,0,0, 1, 1,0,0, 4, "r_in_stall");
    step(0,1, 3,1,0,0,0, 0,0,0, 0,0,0, 1, 0,0,0, 0, "r_after");

    // branch hazards
    step(0,1, 5,1,6,1,1, 1,0,5, 0,0,0, 0, 1,0,0, -1, "br_ex_alu");
    step(0,1, 5,1,6,1,1, 0,0,0, 1,1,5, 0, 1,0,0, -1, "br_mem_ld");
    step(0,1, 5,1,6,1,1, 0,0,0, 1,0,5, 0, FWD ? 0 : 1, FWD ? 2 : 0, 0, -1, "br_mem_alu");
    step(0,1, 7,1,5,1,1, 1,0,5, 0,0,0, 0, 1,0,0, -1, "br_rt_ex");
    step(0,1, 5,1,0,0,0, 1,0,5, 0,0,0, 0, FWD ? 0 : 1, FWD ? 1 : 0, 0, -1, "alu_fwd_mem");

    // RAW on rt with exec and mem both writing $4
    step(0,1, 7,1,4,1,0, 1,0,4, 1,0,4, 0, FWD ? 0 : 1, 0, FWD ? 1 : 0, -1, "raw_rt_both");
    step(0,1, 7,1,4,1,0, 0,0,0, 1,0,4, 0, FWD ? 0 : 1, 0, FWD ? 2 : 0, -1, "raw_rt_mem");
    step(0,1, 7,1,4,1,0, 0,0,0, 0,0,0, 0, 0,0,0, -1, "raw_clear");

    // r0, use-flag and valid gating
    step(0,1, 0,1,0,1,0, 1,1,0, 1,0,0, 0, 0,0,0, -1, "r0_ld");
    step(0,1, 3,0,3,0,0, 1,1,3, 0,0,0, 0, 0,0,0, -1, "no_use");
    step(0,0, 3,1,0,0,0, 1,1,3, 0,0,0, 0, 0,0,0, -1, "inval");

    // counter saturation on the 2-bit instance
    step(1,1, 0,0,0,0,0, 0,0,0, 0,0,0, 0, 0,0,0, -1, "rst_s7");
    for (int k = 0; k < 5; k++)
      step(0,1, 5,1,0,0,1, 1,0,5, 0,0,0, 0, 1,0,0, (k < 3) ? k : 3, "sat");
    step(0,1, 0,0,0,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 3, "sat_hold");

    for (int w = 0; w < 10 && exp_q.size() > 0; w++)
      @(negedge i_clock);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 SHALL have parameter NB_REG_ADDR, default 5: register address width.
REQ-002 SHALL have parameter LOAD_EXTRA, default 0: extra stall cycles added after each load-use stall.
REQ-003 SHALL have parameter NB_PERF, default 16: stall-cycle counter width.
REQ-004 SHALL have port i_clock, input, 1: clock, rising edge only.
REQ-005 SHALL have port i_reset, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port i_valid, input, 1: pipeline advance enable.
REQ-007 SHALL have ports i_rs and i_rt, input, NB_REG_ADDR each: decode-stage source registers.
REQ-008 SHALL have ports i_use_rs and i_use_rt, input, 1 each: decode instruction actually reads that source.
REQ-009 SHALL have port i_jmp_branch, input, 1: decode instruction is a branch or jump-register resolved in decode.
REQ-010 SHALL have ports i_we_exec, i_re_exec and i_rd_exec, input, 1/1/NB_REG_ADDR: exec writes a register / exec is a load / exec destination.
REQ-011 SHALL have ports i_we_mem, i_re_mem and i_rd_mem, input, 1/1/NB_REG_ADDR: the same fields for the mem stage.
REQ-012 SHALL have port o_stall, output, 1: freeze PC and IF/ID, insert a bubble into exec.
REQ-013 SHALL have ports o_fwd_rs and o_fwd_rt, output, 2 each: forward select for the decode sources (00 register file, 01 mem-stage result, 10 wb-stage result), valid one cycle ahead of use in exec.
REQ-014 SHALL have port o_stall_cnt, output, NB_PERF: count of stalled cycles.

Function
REQ-015 A match SHALL require the addresses to be equal, the source's use flag set, the producer's write or read-enable set, and the address non-zero; register 0 never matches.
REQ-016 The load-use hazard hz_ld SHALL be asserted when the exec stage is a load (i_re_exec) and matches rs or rt.
REQ-017 The branch hazard hz_br SHALL be asserted when i_jmp_branch is set and either the exec stage writes a matching register (i_we_exec) or the mem stage is a load matching rs or rt.
REQ-018 The FSM SHALL have two states, S_IDLE and S_STALL, plus a down-counter cnt of width clog2(LOAD_EXTRA+1).
REQ-019 In S_IDLE, o_stall SHALL equal hz = hz_ld | hz_br | hz_raw, where hz_raw is defined in REQ-029.
REQ-020 From S_IDLE, when hz_ld and i_valid are both high and LOAD_EXTRA>0, the FSM SHALL go to S_STALL with cnt=LOAD_EXTRA; otherwise it SHALL stay in S_IDLE.
REQ-021 In S_STALL, o_stall SHALL be 1 regardless of hz.
REQ-022 In S_STALL, each i_valid cycle SHALL decrement cnt, and the FSM SHALL return to S_IDLE on the cycle cnt==1 is consumed.
REQ-023 With i_valid=0, FSM, cnt and o_stall_cnt SHALL hold, and o_stall, o_fwd_rs and o_fwd_rt SHALL be 0.
REQ-024 Forwarding priority per source SHALL be: exec match with i_we_exec & ~i_re_exec gives 01; else mem match with i_we_mem gives 10; else 00.
REQ-025 Forward selects SHALL be 00 whenever o_stall=1.
REQ-026 o_stall_cnt SHALL increment on each cycle with o_stall=1 and i_valid=1, saturating at all-ones.
REQ-027 All hazard and forward outputs SHALL be combinational from inputs and state: zero-latency detection, single-cycle minimum stall.

Reset
REQ-028 On i_reset, the unit SHALL enter S_IDLE with cnt=0 and o_stall_cnt=0; o_stall and forward selects then follow REQ-019 and REQ-024, and reset mid-S_STALL SHALL abort the stall on the next edge.

Configuration
REQ-029 Macro HAZARD_FORWARDING_EN SHALL select the forwarding mode.
- Defined: forwarding per REQ-024 and hz_raw=0.
- Undefined: o_fwd_rs and o_fwd_rt are tied to 00, and hz_raw = any match against exec (i_we_exec) or mem (i_we_mem), so every read-after-write hazard stalls until the producer reaches wb.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the forward-select constants FWD_RF, FWD_MEM and FWD_WB, and the default NB_REG_ADDR.
REQ-031 One sub-module, hazard_match, SHALL implement the REQ-015 address-compare with r0 exclusion; it is instantiated once per source/stage pair.

Verification
REQ-032 Load-use: exec is lw $3, decode is add using rs=3, LOAD_EXTRA=0 -> o_stall=1 for exactly 1 cycle, then o_fwd_rs=10.
REQ-033 Extra latency: same stimulus with LOAD_EXTRA=2 -> o_stall=1 for 3 consecutive valid cycles, o_stall_cnt=3.
REQ-034 Branch: beq rs=5 in decode with exec writing $5 (ALU op) -> 1 stall; next cycle mem is a load to $5 -> stall again.
REQ-035 Forwarding (macro on): exec add $4 and mem add $4, decode reads rt=4 -> o_fwd_rt=01 and no stall; with the macro off -> o_stall=1 for 2 cycles.
REQ-036 r0 and gating: exec lw $0, decode uses rs=0 -> no stall; the REQ-033 stimulus with i_valid dropped mid-stall -> cnt held, stall resumes when i_valid returns; i_reset mid-stall -> S_IDLE next cycle.
